// File: rtl/seg7_signed_display.sv
// Signed result display: captures a two's-complement value, converts its magnitude
// to BCD by shift-add-3, and scans it onto a one-hot-anode 7-segment display.
module seg7_signed_display #(
    parameter int DATA_WIDTH    = 9,
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic                  error_i,
    input  logic                  load_i,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic [DIGITS-1:0]     anode_o,
    output logic [6:0]            seg_o
);
    localparam int BCD_W  = 4 * (DIGITS - 1);
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  TOP_IDX   = IDX_W'(DIGITS - 1);

    localparam logic [6:0] SEG_ZERO  = 7'b1111110;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mag_shift;
    logic [BCD_W-1:0]      bcd;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  conv_ovf;
    logic                  conv_neg;
    logic                  conv_err;
    logic [BCD_W-1:0]      disp_bcd;
    logic                  disp_neg;
    logic                  disp_err;
    logic [SCAN_W-1:0]     scan_cnt;

    logic [DATA_WIDTH-1:0] mag_in;
    logic [BCD_W-1:0]      bcd_adj;
    logic [BCD_W:0]        bcd_shifted;
    logic [3:0]            digit_at [DIGITS];
    logic [DIGITS-1:0]     upper_zero;
    logic [DIGITS-1:0]     anode_next;
    logic [IDX_W-1:0]      idx_next;
    logic [6:0]            seg_next;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'b1111110;
            4'd1:    bcd_to_seg = 7'b0110000;
            4'd2:    bcd_to_seg = 7'b1101101;
            4'd3:    bcd_to_seg = 7'b1111001;
            4'd4:    bcd_to_seg = 7'b0110011;
            4'd5:    bcd_to_seg = 7'b1011011;
            4'd6:    bcd_to_seg = 7'b1011111;
            4'd7:    bcd_to_seg = 7'b1110000;
            4'd8:    bcd_to_seg = 7'b1111111;
            4'd9:    bcd_to_seg = 7'b1111011;
            default: bcd_to_seg = 7'b0000000;
        endcase
    endfunction

    // Unary minus on the unsigned view maps -2^(W-1) onto 2^(W-1), which still fits.
    assign mag_in = value_i[DATA_WIDTH-1] ? (-value_i) : value_i;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS - 1; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? (bcd[4*gi +: 4] + 4'd3)
                                                                 : bcd[4*gi +: 4];
            assign digit_at[gi] = disp_bcd[4*gi +: 4];
        end
    endgenerate
    assign digit_at[DIGITS-1] = 4'd0;

    // The bit leaving the top BCD digit is a carry into a decade we cannot display.
    assign bcd_shifted = {bcd_adj, mag_shift[DATA_WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            overflow_o <= 1'b0;
            mag_shift  <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            conv_ovf   <= 1'b0;
            conv_neg   <= 1'b0;
            conv_err   <= 1'b0;
            disp_bcd   <= '0;
            disp_neg   <= 1'b0;
            disp_err   <= 1'b0;
        end else begin
            busy_o <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (load_i && !busy_o) begin
                        mag_shift <= mag_in;
                        conv_neg  <= value_i[DATA_WIDTH-1];
                        conv_err  <= error_i;
                        bcd       <= '0;
                        conv_ovf  <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    mag_shift <= mag_shift << 1;
                    bcd       <= bcd_shifted[BCD_W-1:0];
                    conv_ovf  <= conv_ovf | bcd_shifted[BCD_W];
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_bcd   <= bcd;
                    disp_neg   <= conv_neg;
                    disp_err   <= conv_err;
                    overflow_o <= conv_ovf;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        anode_next = (scan_cnt == SCAN_LAST) ? {anode_o[DIGITS-2:0], anode_o[DIGITS-1]} : anode_o;
        idx_next   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (anode_next[k]) begin
                idx_next = IDX_W'(k);
            end
        end
        upper_zero             = '0;
        upper_zero[DIGITS-1]   = 1'b1;
        for (int k = DIGITS - 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (digit_at[k] == 4'd0);
        end
    end

    always_comb begin
        seg_next = SEG_ZERO;
        if (disp_err || overflow_o) begin
            seg_next = (idx_next == '0) ? SEG_E : SEG_ZERO;
        end else if (idx_next == TOP_IDX) begin
            seg_next = disp_neg ? SEG_MINUS : ((BLANK_LEADING != 0) ? SEG_BLANK : SEG_ZERO);
        end else if ((BLANK_LEADING != 0) && (idx_next != '0) && upper_zero[idx_next]) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = bcd_to_seg(digit_at[idx_next]);
        end
    end

    // Segments are decoded for the anode that becomes active on this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            anode_o  <= DIGITS'(1);
            seg_o    <= SEG_ZERO;
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SCAN_W'(1);
            anode_o  <= anode_next;
            seg_o    <= seg_next;
        end
    end
endmodule
